led_scan_ctrl: RTL and testbench

Time-multiplexed scanner for the board's 8-digit common-anode seven-segment display. It holds a 32-bit display word and walks one digit at a time at a fixed refresh rate. Each step it presents that digit's 4-bit nibble to the downstream hex-to-segment decoder and drives the matching active-low digit enable. Writes are double-buffered so that the displayed word changes only at a frame boundary, which prevents tearing.

---
 rtl/led_pkg.sv | 20 ++
 rtl/led_tick_div.sv | 29 ++
 rtl/led_scan_ctrl.sv | 92 +++++++++
 tb/tb_led_scan_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared constants and helpers for the 8-digit seven-segment scanner.
package led_pkg;

   localparam int LED_DIGITS           = 8;
   localparam int LED_NIBBLE_W         = 4;
   localparam int LED_WORD_W           = LED_DIGITS * LED_NIBBLE_W;
   localparam int LED_IDX_W            = 3;
   localparam int LED_DIV_W            = 20;
   localparam int LED_SCAN_DIV_DEFAULT = 100_000;

   localparam logic [LED_DIGITS-1:0] LED_EN_OFF = 8'hFF;

   typedef logic [LED_IDX_W-1:0] digit_idx_t;

   // Active-low one-cold enable for a digit position.
   function automatic logic [LED_DIGITS-1:0] digit_enable(input digit_idx_t idx);
      return ~(LED_DIGITS'(1) << idx);
   endfunction

endpackage

// File: rtl/led_tick_div.sv
// Free-running slot divider: tick is high in the last cycle of every DIV-cycle slot.
module led_tick_div
   import led_pkg::*;
#(
   parameter int DIV = LED_SCAN_DIV_DEFAULT
)
(
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam logic [LED_DIV_W-1:0] DIV_LAST = LED_DIV_W'(DIV - 1);

   logic [LED_DIV_W-1:0] div_cnt;

   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/led_scan_ctrl.sv
// Time-multiplexed 8-digit display scanner with frame-synchronous double-buffered writes.
// Optional leading-zero blanking is enabled by defining LED_SCAN_BLANK_EN.
module led_scan_ctrl
   import led_pkg::*;
#(
   parameter int SCAN_DIV = LED_SCAN_DIV_DEFAULT
)
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en,
   input  logic [LED_WORD_W-1:0]   wr_data,
   output logic [LED_DIGITS-1:0]   led_en,
   output logic [LED_NIBBLE_W-1:0] digit_data,
   output logic                    frame_start
);

   logic                  tick;
   logic                  frame_load;
   digit_idx_t            idx;
   digit_idx_t            idx_next;
   logic [LED_WORD_W-1:0] pending;
   logic                  pend_vld;
   logic [LED_WORD_W-1:0] shown;
   logic [LED_WORD_W-1:0] shown_next;
   logic [LED_DIGITS-1:0] lit;

   led_tick_div #(
      .DIV (SCAN_DIV)
   ) u_tick_div (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   assign idx_next   = idx + 1'b1;
   assign frame_load = tick && (idx == digit_idx_t'(LED_DIGITS - 1));

   // A write landing on the frame-load edge goes straight to the display word.
   always_comb begin
      shown_next = shown;
      if (frame_load) begin
         if (wr_en) begin
            shown_next = wr_data;
         end else if (pend_vld) begin
            shown_next = pending;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < LED_DIGITS; gi++) begin : g_lit
`ifdef LED_SCAN_BLANK_EN
         if (gi == 0) begin : g_first
            assign lit[gi] = 1'b1;
         end else begin : g_upper
            assign lit[gi] = |shown_next[LED_WORD_W-1:LED_NIBBLE_W*gi];
         end
`else
         assign lit[gi] = 1'b1;
`endif
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx         <= '1;
         pending     <= '0;
         pend_vld    <= 1'b0;
         shown       <= '0;
         led_en      <= LED_EN_OFF;
         digit_data  <= '0;
         frame_start <= 1'b0;
      end else begin
         shown       <= shown_next;
         frame_start <= frame_load;
         if (frame_load) begin
            pend_vld <= 1'b0;
         end else if (wr_en) begin
            pending  <= wr_data;
            pend_vld <= 1'b1;
         end
         if (tick) begin
            idx        <= idx_next;
            digit_data <= shown_next[LED_NIBBLE_W*idx_next +: LED_NIBBLE_W];
            led_en     <= lit[idx_next] ? digit_enable(idx_next) : LED_EN_OFF;
         end
      end
   end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Self-checking bench for led_scan_ctrl (SCAN_DIV=4) against a cycle-count reference model.
module tb_led_scan_ctrl;

   localparam int DIV   = 4;
   localparam int FRAME = 8 * DIV;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic        wr_en   = 1'b0;
   logic [31:0] wr_data = '0;
   logic [7:0]  led_en;
   logic [3:0]  digit_data;
   logic        frame_start;

   int n_checks = 0;
   int n_errors = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   led_scan_ctrl #(
      .SCAN_DIV (DIV)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .led_en      (led_en),
      .digit_data  (digit_data),
      .frame_start (frame_start)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at t=%0t", tag, act, exp, $time);
      end
   endtask

   // Reference model: the slot and digit follow directly from the number of
   // clock edges since reset release; the display word follows the write rules.
   int          m_cyc;
   logic [31:0] m_shown, m_pend, m_new;
   logic        m_pv;
   logic        m_tick, m_fl, m_lit;
   int          m_d;
   logic [7:0]  e_led;
   logic [3:0]  e_dig;
   logic        e_fs;

   always_comb begin
      m_tick = (m_cyc % DIV) == DIV - 1;
      m_d    = (m_cyc / DIV) % 8;
      m_fl   = m_tick && (m_d == 0);
      m_new  = m_shown;
      if (m_fl && wr_en) m_new = wr_data;
      else if (m_fl && m_pv) m_new = m_pend;
      m_lit = 1'b1;
`ifdef LED_SCAN_BLANK_EN
      if (m_d != 0 && (m_new >> (4 * m_d)) == 32'd0) m_lit = 1'b0;
`endif
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cyc   <= 0;
         m_shown <= '0;
         m_pend  <= '0;
         m_pv    <= 1'b0;
         e_led   <= 8'hFF;
         e_dig   <= '0;
         e_fs    <= 1'b0;
      end else begin
         m_cyc   <= m_cyc + 1;
         m_shown <= m_new;
         e_fs    <= m_fl;
         if (m_fl) begin
            m_pv <= 1'b0;
         end else if (wr_en) begin
            m_pend <= wr_data;
            m_pv   <= 1'b1;
         end
         if (m_tick) begin
            e_dig <= m_new[4*m_d +: 4];
            e_led <= m_lit ? ~(8'd1 << m_d) : 8'hFF;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model led_en", {24'd0, led_en}, {24'd0, e_led});
         check("model digit_data", {28'd0, digit_data}, {28'd0, e_dig});
         check("model frame_start", {31'd0, frame_start}, {31'd0, e_fs});
      end
   end

   // All helpers are entered and left at a falling edge.
   task automatic write_word(input logic [31:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      $display("WR data=%h cyc=%0d slot_digit=%0d frame_load=%0b", d, m_cyc, m_d, m_fl);
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wait_frame_load();
      int n = 0;
      while (!m_fl && n < 4 * FRAME) begin
         @(negedge clk);
         n++;
      end
      if (!m_fl) check("wait_frame_load timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_cyc_mod(input int r);
      int n = 0;
      while ((m_cyc % FRAME) != r && n < 4 * FRAME) begin
         @(negedge clk);
         n++;
      end
      if ((m_cyc % FRAME) != r) check("wait_cyc_mod timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_frame_start();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (frame_start !== 1'b1 && n < 4 * FRAME);
      check("wait_frame_start", {31'd0, frame_start}, 32'd1);
   endtask

   initial begin
      logic [7:0]  exp_en;
      logic [31:0] w;
      int          k;

      // Reset held for 5 cycles
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      check("rst led_en", {24'd0, led_en}, 32'hFF);
      check("rst digit_data", {28'd0, digit_data}, 32'd0);
      check("rst frame_start", {31'd0, frame_start}, 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < DIV - 1; i++) begin
         @(negedge clk);
         check("post-rst dark", {24'd0, led_en}, 32'hFF);
      end
      @(negedge clk);
      check("first led_en", {24'd0, led_en}, 32'hFE);
      check("first digit_data", {28'd0, digit_data}, 32'd0);
      check("first frame_start", {31'd0, frame_start}, 32'd1);
      @(negedge clk);
      check("frame_start width", {31'd0, frame_start}, 32'd0);

      // Scan order: write one edge before a frame load
      wait_cyc_mod(DIV - 2);
      write_word(32'h8765_4321);
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         k      = i / DIV;
         exp_en = ~(8'd1 << k);
         check("scan digit_data", {28'd0, digit_data}, 32'(k + 1));
         check("scan led_en", {24'd0, led_en}, {24'd0, exp_en});
         check("scan frame_start", {31'd0, frame_start}, {31'd0, (i == 0)});
      end
      @(negedge clk);
      check("frame period", {31'd0, frame_start}, 32'd1);

      // Tear-free update
      wait_frame_load();
      write_word(32'hAAAA_AAAA);
      check("coincident A", {28'd0, digit_data}, 32'hA);
      repeat (13) @(negedge clk);
      write_word(32'h5555_5555);
      begin
         int n = 0;
         while (frame_start !== 1'b1 && n < 2 * FRAME) begin
            check("old word held", {28'd0, digit_data}, 32'hA);
            @(negedge clk);
            n++;
         end
      end
      check("new frame start", {31'd0, frame_start}, 32'd1);
      check("new word digit0", {28'd0, digit_data}, 32'h5);
      write_word(32'h0000_0001);
      write_word(32'h0000_0002);
      wait_frame_start();
      check("last write wins", {28'd0, digit_data}, 32'h2);

      // Write coincident with the frame-load tick
      wait_frame_load();
      write_word(32'hDEAD_BEEF);
      check("coincident digit_data", {28'd0, digit_data}, 32'hF);
      check("coincident led_en", {24'd0, led_en}, 32'hFE);
      check("coincident frame_start", {31'd0, frame_start}, 32'd1);

      // Async reset during digit 5 with a write pending
      wait_cyc_mod(5 * DIV + 1);
      write_word(32'h1234_5678);
      #2 rst_n = 1'b0;
      #1;
      check("async led_en", {24'd0, led_en}, 32'hFF);
      check("async digit_data", {28'd0, digit_data}, 32'd0);
      check("async frame_start", {31'd0, frame_start}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      wait_frame_start();
      for (int i = 0; i < FRAME; i++) begin
         check("pending discarded", {28'd0, digit_data}, 32'd0);
         @(negedge clk);
      end

`ifdef LED_SCAN_BLANK_EN
      // Leading-zero blanking
      wait_frame_load();
      write_word(32'h0000_0120);
      w = 32'h0000_0120;
      for (int i = 0; i < FRAME; i++) begin
         k      = i / DIV;
         exp_en = (k <= 2) ? ~(8'd1 << k) : 8'hFF;
         check("blank led_en", {24'd0, led_en}, {24'd0, exp_en});
         check("blank digit_data", {28'd0, digit_data}, {28'd0, w[4*k +: 4]});
         @(negedge clk);
      end
      wait_frame_load();
      write_word(32'h0000_0000);
      for (int i = 0; i < FRAME; i++) begin
         k      = i / DIV;
         exp_en = (k == 0) ? 8'hFE : 8'hFF;
         check("zero led_en", {24'd0, led_en}, {24'd0, exp_en});
         @(negedge clk);
      end
`endif

      // Randomised writes, including words with leading zeros
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            write_word($urandom >> $urandom_range(0, 31));
         end else begin
            @(negedge clk);
         end
      end
      repeat (2 * FRAME) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
